// File: rtl/lcd_text_scheduler.sv
// Buffers UART bytes in a small FIFO, tracks a 2xCOLS cursor and issues one
// DDRAM address + character write at a time to the LCD writer over req/ack.
module lcd_text_scheduler #(
  parameter int DEPTH = 4,
  parameter int COLS  = 16
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     lcd_req,
  output logic [7:0]               lcd_addr,
  output logic [7:0]               lcd_char,
  input  logic                     lcd_ack,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     cur_row,
  output logic [3:0]               cur_col
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAST_COL = 4'(COLS - 1);

  typedef enum logic [1:0] {IDLE, DECODE, ISSUE, CLEAR} state_t;

  state_t          state, state_n;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop, full;
  logic [7:0]      byte_r, byte_n;
  logic            post_row, post_row_n, clr_row, clr_row_n, row_n;
  logic [3:0]      post_col, post_col_n, clr_col, clr_col_n, col_n;
  logic            req_n;
  logic [7:0]      addr_n, char_n;

  function automatic logic [7:0] addr_of(input logic row, input logic [3:0] col);
    return {1'b1, row, 2'b00, col};
  endfunction

  function automatic logic [4:0] next_pos(input logic row, input logic [3:0] col);
    return (col == LAST_COL) ? {~row, 4'd0} : {row, col + 4'd1};
  endfunction

  function automatic logic [4:0] prev_pos(input logic row, input logic [3:0] col);
    return (col == 4'd0) ? {~row, LAST_COL} : {row, col - 4'd1};
  endfunction

  assign full = (fifo_count == (AW+1)'(DEPTH));
  assign push = rx_valid && !full;
  assign busy = (state != IDLE);

  // Storage has no reset: only entries between the pointers are ever read.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      if (rx_valid && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lcd_req  <= 1'b0;
      lcd_addr <= 8'h80;
      lcd_char <= 8'h20;
      cur_row  <= 1'b0;
      cur_col  <= 4'd0;
      post_row <= 1'b0;
      post_col <= 4'd0;
      clr_row  <= 1'b0;
      clr_col  <= 4'd0;
      byte_r   <= 8'h00;
    end else begin
      state    <= state_n;
      lcd_req  <= req_n;
      lcd_addr <= addr_n;
      lcd_char <= char_n;
      cur_row  <= row_n;
      cur_col  <= col_n;
      post_row <= post_row_n;
      post_col <= post_col_n;
      clr_row  <= clr_row_n;
      clr_col  <= clr_col_n;
      byte_r   <= byte_n;
    end
  end

  // In CLEAR, req drops for one cycle between writes while the next address loads.
  always_comb begin
    state_n    = state;
    pop        = 1'b0;
    byte_n     = byte_r;
    req_n      = lcd_req;
    addr_n     = lcd_addr;
    char_n     = lcd_char;
    row_n      = cur_row;
    col_n      = cur_col;
    post_row_n = post_row;
    post_col_n = post_col;
    clr_row_n  = clr_row;
    clr_col_n  = clr_col;
    case (state)
      IDLE: begin
        if (fifo_count != '0) begin
          pop     = 1'b1;
          byte_n  = mem[rd_ptr];
          state_n = DECODE;
        end
      end
      DECODE: begin
        state_n = IDLE;
        if (byte_r >= 8'h20 && byte_r <= 8'h7E) begin
          addr_n                   = addr_of(cur_row, cur_col);
          char_n                   = byte_r;
          {post_row_n, post_col_n} = next_pos(cur_row, cur_col);
          req_n                    = 1'b1;
          state_n                  = ISSUE;
        end else begin
          case (byte_r)
            8'h0A: begin
              row_n = ~cur_row;
              col_n = 4'd0;
            end
            8'h0D: col_n = 4'd0;
            8'h08: begin
              if (cur_row || cur_col != 4'd0) begin
                {row_n, col_n}           = prev_pos(cur_row, cur_col);
                {post_row_n, post_col_n} = {row_n, col_n};
                addr_n                   = addr_of(row_n, col_n);
                char_n                   = 8'h20;
                req_n                    = 1'b1;
                state_n                  = ISSUE;
              end
            end
            8'h0C: begin
              clr_row_n = 1'b0;
              clr_col_n = 4'd0;
              state_n   = CLEAR;
            end
            default: ;
          endcase
        end
      end
      ISSUE: begin
        if (lcd_ack) begin
          req_n   = 1'b0;
          row_n   = post_row;
          col_n   = post_col;
          state_n = IDLE;
        end
      end
      CLEAR: begin
        if (!lcd_req) begin
          addr_n = addr_of(clr_row, clr_col);
          char_n = 8'h20;
          req_n  = 1'b1;
        end else if (lcd_ack) begin
          req_n = 1'b0;
          if (clr_row && clr_col == LAST_COL) begin
            row_n   = 1'b0;
            col_n   = 4'd0;
            state_n = IDLE;
          end else begin
            {clr_row_n, clr_col_n} = next_pos(clr_row, clr_col);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_text_scheduler.sv
// Directed, table-driven bench for lcd_text_scheduler with hand-written
// sequences for timing, wrap-around, clear, overflow and mid-write reset.
module tb_lcd_text_scheduler;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       lcd_ack = 1'b0;
  logic       lcd_req, busy, overflow, cur_row;
  logic [7:0] lcd_addr, lcd_char;
  logic [2:0] fifo_count;
  logic [3:0] cur_col;

  int checks = 0;
  int failures = 0;

  lcd_text_scheduler #(.DEPTH(4), .COLS(16)) dut (
    .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .lcd_req(lcd_req), .lcd_addr(lcd_addr), .lcd_char(lcd_char),
    .lcd_ack(lcd_ack), .busy(busy), .overflow(overflow),
    .fifo_count(fifo_count), .cur_row(cur_row), .cur_col(cur_col)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    bit         writes;
    logic [7:0] addr;
    logic [7:0] chr;
    logic       row;
    logic [3:0] col;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge CLK);
    rx_valid = 1'b0;
    lcd_ack  = 1'b0;
    reset    = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
  endtask

  // Byte is pushed on the rising edge inside this task; returns on the following negedge.
  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic waitReq(input string name);
    int n = 0;
    while (!lcd_req && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checkOutput({name, " req"}, 32'(lcd_req), 32'd1);
  endtask

  task automatic ackPulse();
    lcd_ack = 1'b1;
    @(negedge CLK);
    lcd_ack = 1'b0;
  endtask

  initial begin
    logic seen;
    vecs[0]  = '{8'h41, 1'b1, 8'h80, 8'h41, 1'b0, 4'd1};
    vecs[1]  = '{8'h7A, 1'b1, 8'h81, 8'h7A, 1'b0, 4'd2};
    vecs[2]  = '{8'h0A, 1'b0, 8'h00, 8'h00, 1'b1, 4'd0};
    vecs[3]  = '{8'h7E, 1'b1, 8'hC0, 8'h7E, 1'b1, 4'd1};
    vecs[4]  = '{8'h0D, 1'b0, 8'h00, 8'h00, 1'b1, 4'd0};
    vecs[5]  = '{8'h08, 1'b1, 8'h8F, 8'h20, 1'b0, 4'd15};
    vecs[6]  = '{8'h20, 1'b1, 8'h8F, 8'h20, 1'b1, 4'd0};
    vecs[7]  = '{8'h7F, 1'b0, 8'h00, 8'h00, 1'b1, 4'd0};
    vecs[8]  = '{8'h1F, 1'b0, 8'h00, 8'h00, 1'b1, 4'd0};
    vecs[9]  = '{8'h0A, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0};
    vecs[10] = '{8'h08, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0};
    vecs[11] = '{8'h80, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0};
    vecs[12] = '{8'h31, 1'b1, 8'h80, 8'h31, 1'b0, 4'd1};
    vecs[13] = '{8'h08, 1'b1, 8'h80, 8'h20, 1'b0, 4'd0};

    reset = 1'b1;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    checkOutput("reset req", 32'(lcd_req), 32'd0);
    checkOutput("reset addr", 32'(lcd_addr), 32'h80);
    checkOutput("reset char", 32'(lcd_char), 32'h20);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    checkOutput("reset count", 32'(fifo_count), 32'd0);
    checkOutput("reset cursor", {27'd0, cur_row, cur_col}, 32'd0);

    // First-write latency and a three-cycle held request.
    applyStimulus(8'h41);
    @(negedge CLK);
    checkOutput("latency N+1 req", 32'(lcd_req), 32'd0);
    checkOutput("latency N+1 busy", 32'(busy), 32'd1);
    @(negedge CLK);
    checkOutput("latency N+2 req", 32'(lcd_req), 32'd1);
    checkOutput("first addr", 32'(lcd_addr), 32'h80);
    checkOutput("first char", 32'(lcd_char), 32'h41);
    @(negedge CLK);
    checkOutput("hold 2 req", 32'(lcd_req), 32'd1);
    @(negedge CLK);
    checkOutput("hold 3 req", 32'(lcd_req), 32'd1);
    ackPulse();
    checkOutput("after ack req", 32'(lcd_req), 32'd0);
    checkOutput("after ack busy", 32'(busy), 32'd0);
    checkOutput("after ack cursor", {27'd0, cur_row, cur_col}, 32'h01);

    // Table of single bytes from cursor (0,0).
    doReset();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].data);
      if (vecs[i].writes) begin
        waitReq($sformatf("vec%0d", i));
        checkOutput($sformatf("vec%0d addr", i), 32'(lcd_addr), 32'(vecs[i].addr));
        checkOutput($sformatf("vec%0d char", i), 32'(lcd_char), 32'(vecs[i].chr));
        ackPulse();
      end else begin
        seen = 1'b0;
        repeat (3) begin
          @(negedge CLK);
          seen = seen | lcd_req;
        end
        checkOutput($sformatf("vec%0d no req", i), 32'(seen), 32'd0);
      end
      checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
      checkOutput($sformatf("vec%0d cursor", i), {27'd0, cur_row, cur_col},
                  {27'd0, vecs[i].row, vecs[i].col});
    end

    // 33 printable writes walk both rows and wrap to the origin.
    doReset();
    for (int i = 0; i < 33; i++) begin
      applyStimulus(8'h41 + 8'(i % 26));
      waitReq($sformatf("wrap%0d", i));
      checkOutput($sformatf("wrap%0d addr", i), 32'(lcd_addr),
                  (i % 32) < 16 ? 32'h80 + 32'(i % 32) : 32'hC0 + 32'((i % 32) - 16));
      ackPulse();
    end
    checkOutput("wrap cursor", {27'd0, cur_row, cur_col}, 32'h01);

    // Form feed clears all 32 cells with a one-cycle gap between writes.
    applyStimulus(8'h0C);
    for (int k = 0; k < 32; k++) begin
      waitReq($sformatf("clr%0d", k));
      checkOutput($sformatf("clr%0d addr", k), 32'(lcd_addr),
                  k < 16 ? 32'h80 + 32'(k) : 32'hC0 + 32'(k - 16));
      checkOutput($sformatf("clr%0d char", k), 32'(lcd_char), 32'h20);
      ackPulse();
      checkOutput($sformatf("clr%0d gap", k), 32'(lcd_req), 32'd0);
      if (k < 31) begin
        @(negedge CLK);
        checkOutput($sformatf("clr%0d rerise", k), 32'(lcd_req), 32'd1);
      end
    end
    checkOutput("clr busy", 32'(busy), 32'd0);
    checkOutput("clr cursor", {27'd0, cur_row, cur_col}, 32'd0);

    // Stalled writer: six bytes back to back, one dropped.
    doReset();
    for (int k = 0; k < 6; k++) applyStimulus(8'h61 + 8'(k));
    checkOutput("stall count", 32'(fifo_count), 32'd4);
    checkOutput("stall overflow", 32'(overflow), 32'd1);
    checkOutput("stall req", 32'(lcd_req), 32'd1);
    for (int k = 0; k < 5; k++) begin
      waitReq($sformatf("drain%0d", k));
      checkOutput($sformatf("drain%0d char", k), 32'(lcd_char), 32'h61 + 32'(k));
      checkOutput($sformatf("drain%0d addr", k), 32'(lcd_addr), 32'h80 + 32'(k));
      ackPulse();
    end
    seen = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      seen = seen | lcd_req;
    end
    checkOutput("drain no sixth", 32'(seen), 32'd0);
    checkOutput("drain count", 32'(fifo_count), 32'd0);
    checkOutput("drain overflow sticky", 32'(overflow), 32'd1);

    // Reset while a write is pending and the FIFO is full.
    for (int k = 0; k < 6; k++) applyStimulus(8'h30 + 8'(k));
    checkOutput("pre-reset req", 32'(lcd_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async req", 32'(lcd_req), 32'd0);
    checkOutput("async count", 32'(fifo_count), 32'd0);
    checkOutput("async overflow", 32'(overflow), 32'd0);
    checkOutput("async cursor", {27'd0, cur_row, cur_col}, 32'd0);
    @(negedge CLK);
    reset = 1'b0;
    ackPulse();
    repeat (3) @(negedge CLK);
    checkOutput("late ack req", 32'(lcd_req), 32'd0);
    checkOutput("late ack busy", 32'(busy), 32'd0);
    checkOutput("late ack cursor", {27'd0, cur_row, cur_col}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_text_scheduler.md
# lcd_text_scheduler

Sequencer between the UART receiver and the parallel LCD character writer. It buffers received bytes in a small FIFO and tracks a cursor on the 2x16 display. It interprets printable and control bytes and issues one character write at a time to the writer. Each write carries a DDRAM set-address command and a character, using a req/ack handshake.

## Interface
- DEPTH, 4: FIFO entries, power of two, 2..16.
- COLS, 16: characters per row; rows fixed at 2.
- CLK  in  1  system clock; single clock domain, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- rx_data  in  8  received byte, valid while rx_valid is high.
- rx_valid  in  1  one-cycle strobe; one byte per high cycle.
- lcd_req  out  1  write request to the LCD writer; held until acknowledged.
- lcd_addr  out  8  DDRAM set-address command (0x80|col for row 0, 0xC0|col for row 1).
- lcd_char  out  8  character code to write at lcd_addr.
- lcd_ack  in  1  one-cycle pulse from the writer: current write done.
- busy  out  1  high whenever state ≠ IDLE.
- overflow  out  1  sticky: a byte arrived while the FIFO was full.
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy.
- cur_row  out  1 / cur_col  out  4  current cursor position.

## Operation
- Reset values: lcd_req 0, lcd_addr 0x80, lcd_char 0x20, busy 0, overflow 0, fifo_count 0, cur_row 0, cur_col 0, state IDLE.
- FIFO push: when rx_valid=1 and not full, rx_data is written. When full, the byte is dropped and overflow is set to 1; overflow clears only on reset. A push and a pop in the same cycle are both performed, and the count is unchanged. When full, a same-cycle pop does not free space for the push; the byte is dropped.
- States: IDLE, DECODE, ISSUE, CLEAR.
- IDLE: if the FIFO is non-empty, pop the head into byte_r and go to DECODE.
- DECODE classifies byte_r:
  - 0x20..0x7E: load lcd_addr from the cursor, lcd_char=byte_r, set the post-write cursor to next(cursor), go to ISSUE.
  - 0x0A (LF): cursor → (other row, col 0), no write, go to IDLE.
  - 0x0D (CR): cursor → (same row, col 0), no write, go to IDLE.
  - 0x08 (BS): at (0,0), no action, go to IDLE. Otherwise cursor → prev(cursor), load lcd_addr from the new cursor, lcd_char=0x20, post-write cursor = that same position, go to ISSUE.
  - 0x0C (FF): clr_idx=0, go to CLEAR.
  - All other bytes are discarded; go to IDLE.
- next(): col+1. At col COLS-1, go to (other row, col 0). From (1,COLS-1), wrap to (0,0).
- prev(): the inverse of next(): from (1,0) go to (0,COLS-1).
- ISSUE: lcd_req=1. lcd_addr and lcd_char stay stable until lcd_ack. On lcd_ack, drop lcd_req, commit the post-write cursor, and go to IDLE.
- CLEAR: issue 32 writes of 0x20 in order, each using the ISSUE handshake: row 0 col 0..15 (0x80..0x8F), then row 1 (0xC0..0xCF). After the last ack, the cursor is (0,0) and the state goes to IDLE.
- lcd_ack outside ISSUE/CLEAR-with-req is ignored.
- The FIFO keeps accepting bytes in every state.
- Reset mid-operation: lcd_req drops asynchronously, the FIFO empties, and a pending write is abandoned. The cursor is not restored.

## Timing
- Byte pushed at edge N (FIFO was empty, state IDLE): popped at edge N+1, DECODE at N+1..N+2, lcd_req=1 visible after edge N+2.
- After the ack edge, lcd_req is 0 in the next cycle. The next queued byte then takes two cycles, so lcd_req rises again no earlier than 2 cycles after the ack edge.
- Control bytes with no write (LF, CR, discarded bytes, BS at 0,0) take 2 cycles: pop, then DECODE.
- The cursor update for LF/CR is visible the cycle after DECODE.
- During CLEAR, lcd_req deasserts for exactly 1 cycle between consecutive writes.
- Sustained throughput is bounded by the writer: the FIFO absorbs bursts of up to DEPTH bytes while a write is pending.

## Test plan
- Reset, push 'A' (0x41), ack 3 cycles after req → lcd_addr=0x80, lcd_char=0x41, req high for 3 cycles, then cursor (0,1), busy 0.
- Push 17 printable bytes, acking each → 16th write at 0x8F, 17th at 0xC0. After 32 writes total, the next write is at 0x80.
- Cursor at (1,0), push 0x08 → write 0x20 at 0x8F, cursor (0,15). Push 0x08 at (0,0) → no req, cursor (0,0).
- Push 0x0C → 32 requests with addresses 0x80..0x8F then 0xC0..0xCF, all with char 0x20; final cursor (0,0).
- With the writer stalled (no ack) and DEPTH=4: push 6 bytes → fifo_count=4 (one byte already in ISSUE), overflow=1. Then ack all → exactly 5 writes in push order.
- Assert reset while lcd_req=1 → lcd_req=0 in the same cycle, fifo_count=0, overflow=0, cursor (0,0). A late lcd_ack is ignored.
